// File: rtl/syncgen_param.sv
// syncgen_param: CPC gate-array monitor sync shaping and raster interrupt generator.
// Define SYNCGEN_PRI_EN to add the Plus-style programmable raster interrupt line.
module syncgen_param #(
    parameter int INT_LINES = 52,
    parameter int CNT_W     = 6,
    parameter int HS_DELAY  = 2,
    parameter int HS_MAX    = 4,
    parameter int VS_DELAY  = 2,
    parameter int VS_LINES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cclk_en,
    input  logic             HSYNC_I,
    input  logic             VSYNC_I,
    input  logic             M1_N,
    input  logic             IORQ_N,
    input  logic             irq_reset,
    input  logic [7:0]       pri_line,
    output logic             HSYNC_O,
    output logic             VSYNC_O,
    output logic             SYNC_N,
    output logic             INT_N,
    output logic             mode_sync_en,
    output logic [CNT_W-1:0] int_cnt
);

    localparam int HS_END = HS_DELAY + HS_MAX;
    localparam int VS_END = VS_DELAY + VS_LINES;
    localparam int HD_W   = $clog2(HS_END + 1);
    localparam int VC_W   = $clog2(VS_END + 1);

    localparam logic [HD_W-1:0]  HD_DLY   = HD_W'(HS_DELAY);
    localparam logic [HD_W-1:0]  HD_SAT   = HD_W'(HS_END);
    localparam logic [HD_W-1:0]  HD_ONE   = HD_W'(1);
    localparam logic [VC_W-1:0]  VC_DLY   = VC_W'(VS_DELAY);
    localparam logic [VC_W-1:0]  VC_SAT   = VC_W'(VS_END);
    localparam logic [VC_W-1:0]  VC_ONE   = VC_W'(1);
    localparam logic [CNT_W:0]   IC_ONE   = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   INT_LAST = (CNT_W + 1)'(INT_LINES);

    // Line timing state
    logic            hs_q, hs_d;
    logic            line_ev;
    logic [HD_W-1:0] hdly_q, hdly_d;
    logic            hso_q, hso_d;
    logic            mse_q, mse_d;

    // Frame timing state
    logic            vsi_q, vsi_d;
    logic            vsi_rise;
    logic [VC_W-1:0] vcnt_q, vcnt_d;
    logic            vso_q, vso_d;
    logic            vso_rise;
    logic            sync_n_q, sync_n_d;

    // Interrupt state
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [CNT_W:0]   icnt_inc;
    logic             int_n_q, int_n_d;
    logic             ack_q, ack_d;
    logic             ack;
    logic             raise;
    logic             pri_on;
    logic             pri_hit;

    always_comb begin
        hs_d    = HSYNC_I;
        line_ev = hs_q & ~HSYNC_I;
        hdly_d  = hdly_q;
        if (!HSYNC_I) begin
            hdly_d = '0;
        end else if (cclk_en && hdly_q != HD_SAT) begin
            hdly_d = hdly_q + HD_ONE;
        end
        hso_d = HSYNC_I && (hdly_d >= HD_DLY) && (hdly_d < HD_SAT);
        // Fires once: hso can only fall once per HSYNC_I high period.
        mse_d = hso_q & ~hso_d;
    end

    always_comb begin
        vsi_d    = cclk_en ? VSYNC_I : vsi_q;
        vsi_rise = cclk_en & VSYNC_I & ~vsi_q;
        vcnt_d   = vcnt_q;
        if (vsi_rise) begin
            vcnt_d = '0;
        end else if (line_ev && vcnt_q != VC_SAT) begin
            vcnt_d = vcnt_q + VC_ONE;
        end
        vso_d    = (vcnt_d >= VC_DLY) && (vcnt_d < VC_SAT);
        vso_rise = vso_d & ~vso_q;
        sync_n_d = ~(hso_d ^ vso_d);
    end

`ifdef SYNCGEN_PRI_EN
    logic [7:0] rline_q, rline_d;

    always_comb begin
        rline_d = rline_q;
        if (vso_rise) begin
            rline_d = '0;
        end else if (line_ev) begin
            rline_d = rline_q + 8'd1;
        end
        pri_on  = pri_line != 8'd0;
        pri_hit = line_ev & ~vso_rise & ((rline_q + 8'd1) == pri_line);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rline_q <= '0;
        end else begin
            rline_q <= rline_d;
        end
    end
`else
    logic unused_pri;

    assign unused_pri = ^pri_line;
    assign pri_on     = 1'b0;
    assign pri_hit    = 1'b0;
`endif

    always_comb begin
        icnt_inc = {1'b0, icnt_q} + IC_ONE;
        ack      = ~int_n_q & ~IORQ_N & ~M1_N & ~ack_q;
        ack_d    = ack ? 1'b1 : (M1_N ? 1'b0 : ack_q);
        raise    = 1'b0;
        icnt_d   = icnt_q;
        int_n_d  = int_n_q;
        if (pri_on) begin
            icnt_d = '0;
            raise  = pri_hit;
        end else if (vso_rise) begin
            // Only a counter past mid-period earns a resync interrupt.
            raise  = icnt_q[CNT_W-1];
            icnt_d = '0;
        end else if (line_ev) begin
            if (icnt_inc == INT_LAST) begin
                icnt_d = '0;
                raise  = 1'b1;
            end else begin
                icnt_d = icnt_inc[CNT_W-1:0];
            end
        end
        if (ack) begin
            int_n_d             = 1'b1;
            icnt_d[CNT_W-1]     = 1'b0;
        end
        if (raise) begin
            int_n_d = 1'b0;
        end
        if (irq_reset) begin
            icnt_d  = '0;
            int_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q     <= 1'b0;
            hdly_q   <= '0;
            hso_q    <= 1'b0;
            mse_q    <= 1'b0;
            vsi_q    <= 1'b0;
            vcnt_q   <= VC_SAT;
            vso_q    <= 1'b0;
            sync_n_q <= 1'b1;
            icnt_q   <= '0;
            int_n_q  <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            hs_q     <= hs_d;
            hdly_q   <= hdly_d;
            hso_q    <= hso_d;
            mse_q    <= mse_d;
            vsi_q    <= vsi_d;
            vcnt_q   <= vcnt_d;
            vso_q    <= vso_d;
            sync_n_q <= sync_n_d;
            icnt_q   <= icnt_d;
            int_n_q  <= int_n_d;
            ack_q    <= ack_d;
        end
    end

    assign HSYNC_O      = hso_q;
    assign VSYNC_O      = vso_q;
    assign SYNC_N       = sync_n_q;
    assign INT_N        = int_n_q;
    assign mode_sync_en = mse_q;
    assign int_cnt      = icnt_q;

endmodule

// File: tb/tb_syncgen_param.sv
// tb_syncgen_param: scoreboard bench for syncgen_param with default parameters.
// Stimulus queues per-cycle expectations; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_syncgen_param;

    localparam int CW = 6;

    logic clk = 1'b0;
    logic reset, cclk_en, HSYNC_I, VSYNC_I, M1_N, IORQ_N, irq_reset;
    logic [7:0] pri_line;
    logic HSYNC_O, VSYNC_O, SYNC_N, INT_N, mode_sync_en;
    logic [CW-1:0] int_cnt;

    always #5 clk = ~clk;

    syncgen_param dut (
        .clk          (clk),
        .reset        (reset),
        .cclk_en      (cclk_en),
        .HSYNC_I      (HSYNC_I),
        .VSYNC_I      (VSYNC_I),
        .M1_N         (M1_N),
        .IORQ_N       (IORQ_N),
        .irq_reset    (irq_reset),
        .pri_line     (pri_line),
        .HSYNC_O      (HSYNC_O),
        .VSYNC_O      (VSYNC_O),
        .SYNC_N       (SYNC_N),
        .INT_N        (INT_N),
        .mode_sync_en (mode_sync_en),
        .int_cnt      (int_cnt)
    );

    // Observed vector: {HS, VS, SYNC_N, INT_N, MSE, int_cnt[5:0]}
    localparam logic [10:0] M_HS  = 11'h400;
    localparam logic [10:0] M_VS  = 11'h200;
    localparam logic [10:0] M_SN  = 11'h100;
    localparam logic [10:0] M_IN  = 11'h080;
    localparam logic [10:0] M_MS  = 11'h040;
    localparam logic [10:0] M_CNT = 11'h03f;
    localparam logic [10:0] M_ALL = 11'h7ff;
    localparam logic [10:0] RST_V = 11'h180;

    typedef struct {
        string       name;
        int          cyc;
        logic [10:0] mask;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [10:0] obs;

    assign obs = {HSYNC_O, VSYNC_O, SYNC_N, INT_N, mode_sync_en, int_cnt};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (cur.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d seen at cycle %0d",
                         cur.name, cur.cyc, cyc);
            end else if ((obs & cur.mask) !== (cur.val & cur.mask)) begin
                errors++;
                $display("FAIL %s @%0d: got %b required %b (mask %b)",
                         cur.name, cyc, obs & cur.mask, cur.val & cur.mask, cur.mask);
            end
        end
    end

    function automatic void chk(string nm, logic [10:0] m, logic [10:0] v);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc;
        e.mask = m;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Reference model of the line/frame/interrupt behaviour
    int         m_icnt, m_vcnt;
    bit         m_int_n, m_vs, m_lat, m_vsi, hs_prev, chk_sync;
    logic [7:0] m_rline;

    function automatic void model_reset();
        m_icnt  = 0;
        m_vcnt  = 6;
        m_int_n = 1;
        m_vs    = 0;
        m_lat   = 0;
        m_vsi   = 0;
        hs_prev = 0;
        m_rline = 8'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm);
        bit le, ack, raise, vs_new, vs_rise, vsi_rise, pri_on;
        logic [10:0] m;
        le       = hs_prev && !HSYNC_I;
        hs_prev  = HSYNC_I;
        ack      = !m_int_n && !IORQ_N && !M1_N && !m_lat;
        m_lat    = ack ? 1'b1 : (M1_N ? 1'b0 : m_lat);
        vsi_rise = cclk_en && VSYNC_I && !m_vsi;
        if (cclk_en) m_vsi = VSYNC_I;
        if (vsi_rise) m_vcnt = 0;
        else if (le && m_vcnt < 6) m_vcnt++;
        vs_new  = (m_vcnt >= 2) && (m_vcnt < 6);
        vs_rise = vs_new && !m_vs;
        m_vs    = vs_new;
        raise   = 0;
`ifdef SYNCGEN_PRI_EN
        pri_on = pri_line != 8'd0;
`else
        pri_on = 0;
`endif
        if (pri_on) begin
            raise  = le && !vs_rise && ((m_rline + 8'd1) == pri_line);
            m_icnt = 0;
        end else if (vs_rise) begin
            raise  = m_icnt >= 32;
            m_icnt = 0;
        end else if (le) begin
            if (m_icnt + 1 == 52) begin
                m_icnt = 0;
                raise  = 1;
            end else begin
                m_icnt++;
            end
        end
        if (vs_rise) m_rline = 8'd0;
        else if (le) m_rline = m_rline + 8'd1;
        if (ack) begin
            m_int_n = 1;
            m_icnt  = m_icnt & ~32;
        end
        if (raise) m_int_n = 0;
        if (irq_reset) begin
            m_icnt  = 0;
            m_int_n = 1;
        end
        tick();
        m = M_VS | M_IN | M_CNT;
        if (chk_sync) m = m | M_HS | M_MS | M_SN;
        chk(nm, m, {1'b0, m_vs, ~m_vs, m_int_n, 1'b0, 6'(m_icnt)});
    endtask

    task automatic line(input string nm);
        HSYNC_I = 1'b1;
        step(nm);
        HSYNC_I = 1'b0;
        step(nm);
    endtask

    task automatic do_ack(input string nm);
        IORQ_N = 1'b0;
        M1_N   = 1'b0;
        step(nm);
        IORQ_N = 1'b1;
        M1_N   = 1'b1;
        step(nm);
    endtask

    task automatic vs_pulse(input string nm);
        VSYNC_I = 1'b1;
        cclk_en = 1'b1;
        step(nm);
        VSYNC_I = 1'b0;
        step(nm);
        cclk_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cclk_en = 1'b0; HSYNC_I = 1'b0; VSYNC_I = 1'b0;
        M1_N = 1'b1; IORQ_N = 1'b1; irq_reset = 1'b0; pri_line = 8'd0;
        chk_sync = 0;
        model_reset();
        tick();
        tick();
        chk("reset_vals", M_ALL, RST_V);
        reset = 1'b0;
        step("post_reset");

        // Hsync limiting: 14 ticks high
        HSYNC_I = 1'b1;
        step("hs14_rise");
        for (int j = 1; j <= 14; j++) begin
            bit hs;
            hs = (j >= 2) && (j <= 5);
            cclk_en = 1'b1;
            step("hs14_tick");
            chk("hs14_tick", M_HS | M_MS | M_SN, {hs, 1'b0, ~hs, 1'b0, j == 6, 6'd0});
            cclk_en = 1'b0;
            step("hs14_gap");
            chk("hs14_gap", M_HS | M_MS | M_SN, {hs, 1'b0, ~hs, 8'd0});
        end
        HSYNC_I = 1'b0;
        step("hs14_fall");
        chk("hs14_fall_nopulse", M_HS | M_MS, 11'h000);

        // Short hsync: 3 ticks, ended by HSYNC_I falling
        HSYNC_I = 1'b1;
        step("hs3_rise");
        for (int j = 1; j <= 3; j++) begin
            bit hs;
            hs = j >= 2;
            cclk_en = 1'b1;
            step("hs3_tick");
            chk("hs3_tick", M_HS | M_MS | M_SN, {hs, 1'b0, ~hs, 8'd0});
            cclk_en = 1'b0;
            step("hs3_gap");
        end
        HSYNC_I = 1'b0;
        step("hs3_fall");
        chk("hs3_fall_pulse", M_HS | M_MS | M_SN, M_SN | M_MS);
        step("hs3_after");
        chk("hs3_pulse_once", M_MS, 11'h000);

        // Async reset while HSYNC_O is high
        HSYNC_I = 1'b1;
        tick();
        for (int j = 1; j <= 3; j++) begin
            cclk_en = 1'b1;
            tick();
            cclk_en = 1'b0;
            tick();
        end
        reset = 1'b1;
        chk("async_reset", M_ALL, RST_V);
        HSYNC_I = 1'b0;
        tick();
        chk("reset_held", M_ALL, RST_V);
        reset = 1'b0;
        model_reset();
        chk_sync = 1;
        step("post_reset2");

        // Periodic interrupt every 52 lines, each acknowledged
        for (int k = 1; k <= 300; k++) begin
            line("per_line");
            if (k % 52 == 0) begin
                chk("per_int_low", M_IN | M_CNT, 11'h000);
                IORQ_N = 1'b0;
                M1_N   = 1'b0;
                step("per_ack");
                chk("per_ack_high", M_IN, M_IN);
                IORQ_N = 1'b1;
                M1_N   = 1'b1;
                step("per_ack_rel");
            end
        end
        chk("per_end_cnt", M_CNT, 11'd40);

        // Vsync resync with counter past mid-period
        vs_pulse("vs_a_pulse");
        line("vs_a_l1");
        chk("vs_a_l1", M_VS | M_CNT, 11'd41);
        line("vs_a_l2");
        chk("vs_a_int", M_VS | M_IN | M_CNT, M_VS);
        do_ack("vs_a_ack");
        for (int k = 3; k <= 6; k++) begin
            line("vs_a_line");
            chk("vs_a_len", M_VS, (k <= 5) ? M_VS : 11'h000);
        end

        // Vsync resync with small counter, then a mid-sequence restart
        while (m_icnt != 20) line("vs_b_pre");
        vs_pulse("vs_b_pulse");
        line("vs_b_l1");
        line("vs_b_l2");
        chk("vs_b_noint", M_VS | M_IN | M_CNT, M_VS | M_IN);
        line("vs_b_l3");
        vs_pulse("vs_c_pulse");
        chk("vs_restart_off", M_VS, 11'h000);
        line("vs_c_l1");
        chk("vs_c_l1", M_VS, 11'h000);
        line("vs_c_l2");
        chk("vs_restart_rise", M_VS | M_IN | M_CNT, M_VS | M_IN);
        for (int k = 0; k < 4; k++) line("vs_c_tail");
        chk("vs_c_done", M_VS, 11'h000);

        // Ack and raise on the same clk
        for (int k = 0; k < 60 && m_int_n; k++) line("coll_pre");
        chk("coll_pending", M_IN, 11'h000);
        while (m_icnt != 51) line("coll_cnt");
        HSYNC_I = 1'b1;
        step("coll_hi");
        HSYNC_I = 1'b0;
        IORQ_N  = 1'b0;
        M1_N    = 1'b0;
        step("coll");
        chk("coll_raise_wins", M_IN | M_CNT, 11'h000);
        step("coll_latch");
        chk("coll_latch_hold", M_IN, 11'h000);
        IORQ_N = 1'b1;
        M1_N   = 1'b1;
        step("coll_rel");

        // Software clear with interrupt pending and icnt=45
        while (m_icnt != 45) line("irq_pre");
        chk("irq_pre", M_IN | M_CNT, 11'd45);
        irq_reset = 1'b1;
        step("irq_reset");
        irq_reset = 1'b0;
        chk("irq_reset_clr", M_IN | M_CNT, M_IN);

`ifdef SYNCGEN_PRI_EN
        // Programmable raster line
        pri_line = 8'd100;
        vs_pulse("pri_pulse");
        line("pri_l1");
        line("pri_l2");
        chk("pri_vs_noint", M_VS | M_IN | M_CNT, M_VS | M_IN);
        for (int n = 1; n <= 110; n++) begin
            line("pri_line");
            if (n == 52) chk("pri_no52", M_IN | M_CNT, M_IN);
            if (n == 99) chk("pri_no99", M_IN, M_IN);
            if (n == 100) chk("pri_at100", M_IN | M_CNT, 11'h000);
        end
        do_ack("pri_ack");
        pri_line = 8'd0;
        for (int n = 1; n <= 52; n++) begin
            line("pri_off");
            if (n == 51) chk("pri_off_51", M_IN | M_CNT, M_IN | 11'd51);
        end
        chk("pri_off_52", M_IN | M_CNT, 11'h000);
        do_ack("pri_off_ack");
`endif

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
